// File: rtl/rom_copier.sv
// -----------------------------------------------------------------------------
// rom_copier -- flash-to-SDRAM boot copier
//
// Copies COPY_WORDS words from parallel flash (starting at FL_BASE) into SDRAM
// (starting at RAM_BASE) after reset (AUTO_START=1) or on istart. A reader
// engine fetches flash words into a small FIFO while an independent writer
// engine drains that FIFO into SDRAM, so flash latency overlaps SDRAM writes.
// Both external interfaces use a toggle handshake: a transfer is complete
// when the ack input equals the req output.
//
// Optional feature macro: ROM_COPIER_CSUM_EN
//   defined   : ochecksum is the modulo-2**DW sum of all words acked by SDRAM
//               during the current copy.
//   undefined : ochecksum is tied to zero.
//
// Ports
//   iclk, ireset         clock, synchronous active-high reset
//   istart               start pulse, honoured in IDLE or DONE only
//   oloading             high while a copy is in progress (holds the core)
//   odone                high after a copy completes
//   ocount               SDRAM words written in the current copy
//   ochecksum            running word sum (see macro above)
//   ofl_addr/ofl_req     flash word address / toggle request
//   ifl_ack/ifl_data     flash toggle ack / read data
//   oram_addr/oram_wrdata/oram_req   SDRAM address / write data / request
//   iram_ack             SDRAM toggle ack
//   oram_Wrl/oram_Wrh    byte write enables, high while loading
// -----------------------------------------------------------------------------
module rom_copier #(
  parameter int FL_AW      = 23,
  parameter int RAM_AW     = 24,
  parameter int DW         = 16,
  parameter int COPY_WORDS = 4194304,
  parameter int FL_BASE    = 0,
  parameter int RAM_BASE   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int AUTO_START = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              istart,
  output logic              oloading,
  output logic              odone,
  output logic [FL_AW-1:0]  ocount,
  output logic [DW-1:0]     ochecksum,
  output logic [FL_AW:1]    ofl_addr,
  output logic              ofl_req,
  input  logic              ifl_ack,
  input  logic [DW-1:0]     ifl_data,
  output logic [RAM_AW:1]   oram_addr,
  output logic [DW-1:0]     oram_wrdata,
  output logic              oram_req,
  input  logic              iram_ack,
  output logic              oram_Wrl,
  output logic              oram_Wrh
);

  // Counters carry one extra bit so a full 2**FL_AW copy can be counted.
  localparam int CW = FL_AW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]     COPY_CNT  = CW'(COPY_WORDS);
  localparam logic [PW:0]       FIFO_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [FL_AW-1:0]  FL_START  = FL_AW'(FL_BASE);
  localparam logic [RAM_AW-1:0] RAM_START = RAM_AW'(RAM_BASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   start_copy;
  logic   running;

  // Reader state
  logic [FL_AW-1:0]  fl_addr_reg;
  logic              fl_req_reg;
  logic              fl_busy_reg;
  logic [CW-1:0]     issued_reg;

  // Writer state
  logic [RAM_AW-1:0] ram_addr_reg;
  logic              ram_req_reg;
  logic              ram_busy_reg;
  logic [CW-1:0]     count_reg;
  logic [DW-1:0]     wrdata_reg;

  // FIFO
  logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW:0]       fifo_count_reg;

  logic fl_issue, fl_done, wr_issue, wr_done;

  // ---------------------------------------------------------------------------
  // Top FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_copy = 1'b0;
    oloading   = 1'b0;
    odone      = 1'b0;
    oram_Wrl   = 1'b0;
    oram_Wrh   = 1'b0;
    case (state_reg)
      IDLE: begin
        // IDLE is only ever reached through reset, so AUTO_START fires on the
        // first cycle after reset and never again.
        if ((AUTO_START != 0) || istart) begin
          state_next = RUN;
          start_copy = 1'b1;
        end
      end
      RUN: begin
        oloading = 1'b1;
        oram_Wrl = 1'b1;
        oram_Wrh = 1'b1;
        if (count_reg == COPY_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        odone = 1'b1;
        if (istart) begin
          state_next = RUN;
          start_copy = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign running = (state_reg == RUN);

  // ---------------------------------------------------------------------------
  // Engine strobes
  // ---------------------------------------------------------------------------
  // A new flash read is only issued when nothing is outstanding, so the
  // occupancy test needs no outstanding term; the ack cycle itself has the
  // busy flag set, which forces at least one idle cycle between reads.
  assign fl_issue = running && !fl_busy_reg && (fifo_count_reg < FIFO_CNT)
                    && (issued_reg < COPY_CNT);
  assign fl_done  = running && fl_busy_reg && (ifl_ack == fl_req_reg);
  assign wr_issue = running && !ram_busy_reg && (fifo_count_reg != '0);
  assign wr_done  = running && ram_busy_reg && (iram_ack == ram_req_reg);

  // ---------------------------------------------------------------------------
  // Reader / writer / FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (ireset) begin
      fl_addr_reg    <= FL_START;
      fl_req_reg     <= 1'b0;
      fl_busy_reg    <= 1'b0;
      issued_reg     <= '0;
      ram_addr_reg   <= RAM_START;
      ram_req_reg    <= 1'b0;
      ram_busy_reg   <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else if (start_copy) begin
      // Request toggles keep their parity: the controllers still hold the
      // matching ack level from the previous copy.
      fl_addr_reg    <= FL_START;
      fl_busy_reg    <= 1'b0;
      issued_reg     <= '0;
      ram_addr_reg   <= RAM_START;
      ram_busy_reg   <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (fl_issue) begin
        fl_req_reg  <= ~fl_req_reg;
        fl_busy_reg <= 1'b1;
        issued_reg  <= issued_reg + 1'b1;
      end
      if (fl_done) begin
        fl_busy_reg <= 1'b0;
        fl_addr_reg <= fl_addr_reg + 1'b1;
        wr_ptr_reg  <= wr_ptr_reg + 1'b1;
      end
      if (wr_issue) begin
        ram_req_reg  <= ~ram_req_reg;
        ram_busy_reg <= 1'b1;
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      end
      if (wr_done) begin
        ram_busy_reg <= 1'b0;
        ram_addr_reg <= ram_addr_reg + 1'b1;
        count_reg    <= count_reg + 1'b1;
      end
      case ({fl_done, wr_issue})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // FIFO storage with registered read straight into the SDRAM data register.
  // Push and pop never address the same entry: a pop needs a non-empty FIFO
  // and a push can only land while it is not full.
  always_ff @(posedge iclk) begin
    if (fl_done) begin
      fifo_mem[wr_ptr_reg] <= ifl_data;
    end
    if (wr_issue) begin
      wrdata_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum
  // ---------------------------------------------------------------------------
`ifdef ROM_COPIER_CSUM_EN
  logic [DW-1:0] checksum_reg;

  always_ff @(posedge iclk) begin
    if (ireset || start_copy) begin
      checksum_reg <= '0;
    end else if (wr_done) begin
      // wrdata_reg still holds the acked word; it only reloads on the next
      // write issue, which cannot precede this ack.
      checksum_reg <= checksum_reg + wrdata_reg;
    end
  end

  assign ochecksum = checksum_reg;
`else
  assign ochecksum = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ocount      = count_reg[FL_AW-1:0];
  assign ofl_addr    = fl_addr_reg;
  assign ofl_req     = fl_req_reg;
  assign oram_addr   = ram_addr_reg;
  assign oram_wrdata = wrdata_reg;
  assign oram_req    = ram_req_reg;

endmodule

// File: tb/tb_rom_copier.sv
`timescale 1ns/1ps
module tb_rom_copier;

  localparam int FL_AW      = 23;
  localparam int RAM_AW     = 24;
  localparam int DW         = 16;
  localparam int COPY_WORDS = 8;
  localparam int FL_BASE    = 8388606;   // 2**23-2: flash address wraps
  localparam int RAM_BASE   = 16777213;  // 2**24-3: SDRAM address wraps
  localparam int FIFO_DEPTH = 2;

`ifdef ROM_COPIER_CSUM_EN
  localparam logic [15:0] EXP_CSUM = 16'h968C;
`else
  localparam logic [15:0] EXP_CSUM = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic loading, done;
  logic [22:0] count;
  logic [15:0] csum;
  logic [23:1] fl_addr;
  logic fl_req;
  logic fl_ack = 1'b0;
  logic [15:0] fl_data = 16'h0000;
  logic [24:1] ram_addr;
  logic [15:0] ram_wrdata;
  logic ram_req;
  logic ram_ack = 1'b0;
  logic wrl, wrh;

  always #5 clk = ~clk;

  rom_copier #(
    .FL_AW(FL_AW), .RAM_AW(RAM_AW), .DW(DW), .COPY_WORDS(COPY_WORDS),
    .FL_BASE(FL_BASE), .RAM_BASE(RAM_BASE), .FIFO_DEPTH(FIFO_DEPTH),
    .AUTO_START(0)
  ) dut (
    .iclk(clk), .ireset(rst), .istart(start),
    .oloading(loading), .odone(done), .ocount(count), .ochecksum(csum),
    .ofl_addr(fl_addr), .ofl_req(fl_req), .ifl_ack(fl_ack), .ifl_data(fl_data),
    .oram_addr(ram_addr), .oram_wrdata(ram_wrdata), .oram_req(ram_req),
    .iram_ack(ram_ack), .oram_Wrl(wrl), .oram_Wrh(wrh)
  );

  // Expected transfer contents: flash data = address[15:0] ^ A5A5.
  logic [22:0] exp_fl   [8] = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001,
                                23'h000002, 23'h000003, 23'h000004, 23'h000005};
  logic [15:0] exp_data [8] = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4,
                                16'hA5A7, 16'hA5A6, 16'hA5A1, 16'hA5A0};
  logic [23:0] exp_ram  [8] = '{24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF, 24'h000000,
                                24'h000001, 24'h000002, 24'h000003, 24'h000004};

  // ---------------------------------------------------------------------------
  // Flash and SDRAM controller models (toggle handshake, programmable latency)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        we;
  } wr_t;

  wr_t         ram_log [$];
  logic [22:0] fl_log  [$];
  int          fl_lat = 1;
  int          ram_lat = 1;
  logic        ram_hold = 1'b0;
  int          fl_cnt = 0;
  int          ram_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      fl_ack <= 1'b0;
      fl_cnt <= 0;
    end else if (fl_req != fl_ack) begin
      if (fl_cnt >= fl_lat - 1) begin
        fl_ack  <= fl_req;
        fl_data <= fl_addr[16:1] ^ 16'hA5A5;
        fl_log.push_back(fl_addr);
        fl_cnt  <= 0;
      end else begin
        fl_cnt <= fl_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ram_ack <= 1'b0;
      ram_cnt <= 0;
    end else if ((ram_req != ram_ack) && !ram_hold) begin
      if (ram_cnt >= ram_lat - 1) begin
        ram_ack <= ram_req;
        ram_log.push_back('{ram_addr, ram_wrdata, wrl & wrh});
        ram_cnt <= 0;
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end
  end

  // Request monitor: counts toggles, tracks reads-in-flight minus writes
  // issued (FIFO occupancy plus outstanding read), and flags any toggle
  // while the copier is not loading.
  int   mon_fl = 0, mon_ram = 0, mon_max = 0, idle_tog = 0;
  logic prev_fl = 1'b0, prev_ram = 1'b0, prev_loading = 1'b0;
  logic mon_clr = 1'b0;

  always @(posedge clk) begin
    int nf, nr;
    nf = mon_fl + ((fl_req != prev_fl) ? 1 : 0);
    nr = mon_ram + ((ram_req != prev_ram) ? 1 : 0);
    prev_fl      <= fl_req;
    prev_ram     <= ram_req;
    prev_loading <= loading;
    if (!prev_loading && ((fl_req != prev_fl) || (ram_req != prev_ram)))
      idle_tog <= idle_tog + 1;
    if (mon_clr) begin
      mon_fl  <= 0;
      mon_ram <= 0;
      mon_max <= 0;
    end else begin
      mon_fl  <= nf;
      mon_ram <= nr;
      if (nf - nr > mon_max) mon_max <= nf - nr;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int fl_lat;
    int ram_lat;
    bit stall;
    bit mid_start;
    int exp_count;
    int exp_stall_reads;
  } vec_t;

  vec_t vecs [4];

  task automatic run_copy(input int idx, input vec_t v);
    logic r0;
    fl_lat  = v.fl_lat;
    ram_lat = v.ram_lat;
    ram_log.delete();
    fl_log.delete();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr  = 1'b0;
    ram_hold = v.stall;
    r0 = ram_req;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_loading_set", idx), {31'd0, loading}, 32'd1);
    check($sformatf("v%0d_wr_en_set", idx), {30'd0, wrl, wrh}, 32'd3);
    check($sformatf("v%0d_done_clr", idx), {31'd0, done}, 32'd0);
    check($sformatf("v%0d_count_clr", idx), {9'd0, count}, 32'd0);
    check($sformatf("v%0d_csum_clr", idx), {16'd0, csum}, 32'd0);

    if (v.stall) begin
      for (int k = 0; k < 200 && ram_req == r0; k++) @(negedge clk);
      repeat (50) @(negedge clk);
      check($sformatf("v%0d_stall_reads", idx), mon_fl, v.exp_stall_reads);
      check($sformatf("v%0d_stall_writes", idx), ram_log.size(), 0);
      check($sformatf("v%0d_stall_loading", idx), {31'd0, loading}, 32'd1);
      ram_hold = 1'b0;
    end
    if (v.mid_start) begin
      for (int k = 0; k < 500 && count < 3; k++) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    for (int k = 0; k < 2000 && !done; k++) @(negedge clk);
    check($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d_count", idx), {9'd0, count}, v.exp_count);
    check($sformatf("v%0d_loading_end", idx), {31'd0, loading}, 32'd0);
    check($sformatf("v%0d_wr_en_end", idx), {30'd0, wrl, wrh}, 32'd0);
    check($sformatf("v%0d_csum", idx), {16'd0, csum}, {16'd0, EXP_CSUM});
    check($sformatf("v%0d_ram_words", idx), ram_log.size(), v.exp_count);
    check($sformatf("v%0d_fl_reads", idx), fl_log.size(), v.exp_count);
    check($sformatf("v%0d_buffer_bound", idx), (mon_max <= FIFO_DEPTH) ? 1 : 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < ram_log.size()) begin
        check($sformatf("v%0d_ram_addr%0d", idx, i), {8'd0, ram_log[i].addr}, {8'd0, exp_ram[i]});
        check($sformatf("v%0d_ram_data%0d", idx, i), {16'd0, ram_log[i].data}, {16'd0, exp_data[i]});
        check($sformatf("v%0d_ram_we%0d", idx, i), {31'd0, ram_log[i].we}, 32'd1);
      end
      if (i < fl_log.size()) begin
        check($sformatf("v%0d_fl_addr%0d", idx, i), {9'd0, fl_log[i]}, {9'd0, exp_fl[i]});
      end
    end
    $display("copy v%0d: fl_lat=%0d ram_lat=%0d words=%0d count=%0d csum=%h",
             idx, v.fl_lat, v.ram_lat, ram_log.size(), count, csum);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_loading"}, {31'd0, loading}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_count"}, {9'd0, count}, 32'd0);
    check({tag, "_csum"}, {16'd0, csum}, 32'd0);
    check({tag, "_fl_req"}, {31'd0, fl_req}, 32'd0);
    check({tag, "_ram_req"}, {31'd0, ram_req}, 32'd0);
    check({tag, "_wr_en"}, {30'd0, wrl, wrh}, 32'd0);
    check({tag, "_fl_addr"}, {9'd0, fl_addr}, 32'h007FFFFE);
    check({tag, "_ram_addr"}, {8'd0, ram_addr}, 32'h00FFFFFD);
  endtask

  vec_t abort_v;

  initial begin
    // fl_lat, ram_lat, stall, mid_start, exp_count, exp_stall_reads
    vecs[0] = '{3, 5, 1'b0, 1'b0, 8, 0};
    vecs[1] = '{1, 1, 1'b0, 1'b1, 8, 0};
    vecs[2] = '{2, 2, 1'b1, 1'b0, 8, 3};   // 1 write held + 2 buffered
    vecs[3] = '{6, 1, 1'b0, 1'b0, 8, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // AUTO_START=0: nothing moves until istart.
    repeat (6) @(negedge clk);
    check("idle_no_fl_req", {31'd0, fl_req}, 32'd0);
    check("idle_no_loading", {31'd0, loading}, 32'd0);
    check("idle_no_done", {31'd0, done}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_copy(v, vecs[v]);
    end

    // Abort at word 5, then a full restart.
    fl_lat  = 2;
    ram_lat = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && count < 5; k++) @(negedge clk);
    check("abort_reached5", {9'd0, count}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_idle_fl_req", {31'd0, fl_req}, 32'd0);
    check("abort_idle_loading", {31'd0, loading}, 32'd0);
    abort_v = '{2, 2, 1'b0, 1'b0, 8, 0};
    run_copy(9, abort_v);

    check("idle_toggles", idle_tog, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
